// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stage enables/flushes, load-use and branch-operand
// stalls, and a multi-cycle divide freeze. Optional counters: PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CW         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        branch_d,
  input  logic        pcsrc_d,
  input  logic        jump_d,
  input  logic [4:0]  rt_e,
  input  logic [4:0]  write_reg_e,
  input  logic        regwrite_e,
  input  logic        memtoreg_e,
  input  logic        div_start_e,
  input  logic [4:0]  write_reg_m,
  input  logic        memtoreg_m,
  output logic        en_f,
  output logic        en_d,
  output logic        en_e,
  output logic        en_m,
  output logic        en_w,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        div_busy,
  output logic        div_done
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            div_stall;
  logic            lw_stall;
  logic            br_stall;
  logic            hit_e;
  logic            hit_m;

  // Counter loads DIV_CYCLES-2: the issue cycle and the count-0 cycle are both stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (div_start_e) begin
            state_q <= StBusy;
            cnt_q   <= CW'(DIV_CYCLES - 2);
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    div_stall = !rst && ((state_q == StIdle && div_start_e) || state_q == StBusy);
    lw_stall  = memtoreg_e && (rt_e != 5'd0) && (rt_e == rs_d || rt_e == rt_d);
    hit_e     = regwrite_e && (write_reg_e != 5'd0) &&
                (write_reg_e == rs_d || write_reg_e == rt_d);
    hit_m     = memtoreg_m && (write_reg_m != 5'd0) &&
                (write_reg_m == rs_d || write_reg_m == rt_d);
    br_stall  = branch_d && (hit_e || hit_m);

    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    en_m     = 1'b1;
    en_w     = 1'b1;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    div_busy = div_stall;
    div_done = !rst && (state_q == StDone);

    // Reset forces the pass-through pattern regardless of what the stages present.
    if (rst) begin
      div_busy = 1'b0;
    end else if (div_stall) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      flush_m = 1'b1;
    end else if (lw_stall || br_stall) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      flush_e = 1'b1;
    end else if (pcsrc_d || jump_d) begin
      flush_d = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_f && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (flush_d && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  // Statistics disabled: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with DIV_CYCLES=4; stats checks when
// PIPE_HAZARD_STATS_EN is defined.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs_d = '0, rt_d = '0, rt_e = '0, write_reg_e = '0, write_reg_m = '0;
  logic branch_d = 0, pcsrc_d = 0, jump_d = 0, regwrite_e = 0, memtoreg_e = 0;
  logic div_start_e = 0, memtoreg_m = 0;
  logic en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, div_busy, div_done;
`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.DIV_CYCLES(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .pcsrc_d(pcsrc_d), .jump_d(jump_d), .rt_e(rt_e), .write_reg_e(write_reg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .div_start_e(div_start_e),
    .write_reg_m(write_reg_m), .memtoreg_m(memtoreg_m), .en_f(en_f), .en_d(en_d),
    .en_e(en_e), .en_m(en_m), .en_w(en_w), .flush_d(flush_d), .flush_e(flush_e),
    .flush_m(flush_m), .div_busy(div_busy), .div_done(div_done)
`ifdef PIPE_HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e,flush_m, div_busy,div_done}
  localparam logic [9:0] NORM = 10'b11111_000_00;
  localparam logic [9:0] HAZ  = 10'b00111_010_00;
  localparam logic [9:0] BR   = 10'b11111_100_00;
  localparam logic [9:0] DIV  = 10'b00011_001_10;
  localparam logic [9:0] DONE = 10'b11111_000_01;

  typedef struct {
    logic [9:0] exp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, div_busy, div_done};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.exp);
      end
    end
  end

  task automatic clr();
    rs_d = 0; rt_d = 0; rt_e = 0; write_reg_e = 0; write_reg_m = 0;
    branch_d = 0; pcsrc_d = 0; jump_d = 0; regwrite_e = 0; memtoreg_e = 0;
    div_start_e = 0; memtoreg_m = 0;
  endtask

  task automatic step(input logic [9:0] exp, input string nm);
    exp_t e;
    e.exp = exp;
    e.nm  = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input logic [31:0] act, input logic [31:0] exp, input string nm);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held with a load-use hazard and divide presented: pass-through pattern.
    memtoreg_e = 1; rt_e = 5; rs_d = 5; div_start_e = 1;
    step(NORM, "reset_forces_idle");
    rst = 0; clr();
    step(NORM, "idle_after_reset");

    memtoreg_e = 1; rt_e = 5; rs_d = 5;
    step(HAZ, "lw_rs_hazard");
    rt_e = 0; rs_d = 0;
    step(NORM, "lw_reg0_no_hazard");
    rt_e = 9; rs_d = 1; rt_d = 9;
    step(HAZ, "lw_rt_hazard");
    clr();

    branch_d = 1; rs_d = 7; write_reg_m = 7; memtoreg_m = 1;
    step(HAZ, "br_mem_load_hazard");
    memtoreg_m = 0; pcsrc_d = 1;
    step(BR, "br_taken_flush");
    clr();
    branch_d = 1; rt_d = 3; regwrite_e = 1; write_reg_e = 3;
    step(HAZ, "br_ex_write_hazard");
    rt_d = 0; write_reg_e = 0;
    step(NORM, "br_reg0_no_hazard");
    clr();
    jump_d = 1;
    step(BR, "jump_flush");
    clr();

    // Divide: held 5 cycles -> 4 busy + 1 done; hazards during busy are masked.
    div_start_e = 1;
    step(DIV, "div_issue");
    memtoreg_e = 1; rt_e = 4; rs_d = 4; pcsrc_d = 1;
    step(DIV, "div_masks_lw_br_1");
    step(DIV, "div_masks_lw_br_2");
    memtoreg_e = 0; rt_e = 0; rs_d = 0; pcsrc_d = 0;
    step(DIV, "div_busy_last");
    step(DONE, "div_done_no_retrigger");
    div_start_e = 0; pcsrc_d = 1;
    step(BR, "branch_flush_after_div");
    clr();

    // Reset in BUSY with counter at 2.
    div_start_e = 1;
    step(DIV, "div2_issue");
    rst = 1;
    step(NORM, "reset_mid_divide");
    rst = 0; div_start_e = 0;
    step(NORM, "idle_after_mid_reset");
`ifdef PIPE_HAZARD_STATS_EN
    chk32(stall_cnt, 32'd0, "stall_cnt_after_reset");
    chk32(flush_cnt, 32'd0, "flush_cnt_after_reset");
`endif
    div_start_e = 1;
    step(DIV, "div3_issue");
    step(DIV, "div3_busy1");
    step(DIV, "div3_busy2");
    step(DIV, "div3_busy3");
    step(DONE, "div3_done");
    div_start_e = 0;
    step(NORM, "idle_after_div3");
`ifdef PIPE_HAZARD_STATS_EN
    chk32(stall_cnt, 32'd4, "stall_cnt_after_div");
    jump_d = 1;
    step(BR, "jump_for_flush_cnt");
    jump_d = 0;
    chk32(flush_cnt, 32'd1, "flush_cnt_after_jump");
`endif

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
